// File: rtl/mem_port_arbiter.sv
// Shares the cache/SRAM controller request port between IF and MEM, one transaction at a time.
// MEM has priority; a starvation counter forces IF ahead after STARVE_MAX consecutive MEM wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_R_en,
  output logic [DATA_W-1:0] if_data_out,
  output logic              if_freeze,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_R_en,
  input  logic              mem_W_en,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_freeze,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_data_in,
  output logic              ctrl_R_en,
  output logic              ctrl_W_en,
  input  logic [DATA_W-1:0] ctrl_data_out,
  input  logic              ctrl_freeze
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                op_w_q, op_w_d;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                r_en_q, r_en_d;
  logic                w_en_q, w_en_d;

  logic mem_req;
  logic mem_wins;
  logic done;

  assign mem_req  = mem_R_en | mem_W_en;
  // MEM wins unless starved out IF is waiting; with no IF request MEM is the fallback.
  assign mem_wins = (mem_req && (32'(starve_q) < STARVE_MAX)) || !if_R_en;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    op_w_d   = op_w_q;
    addr_d   = addr_q;
    data_d   = data_q;
    r_en_d   = r_en_q;
    w_en_d   = w_en_q;
    starve_d = if_R_en ? starve_q : 4'd0;
    case (state_q)
      StIdle: begin
        if (if_R_en || mem_req) begin
          state_d = StIssue;
          grant_d = mem_wins;
          if (mem_wins) begin
            addr_d = mem_addr;
            data_d = mem_data_in;
            // Simultaneous read and write performs the read only.
            op_w_d = mem_W_en & ~mem_R_en;
            if (if_R_en) begin
              starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
            end
          end else begin
            addr_d   = if_addr;
            data_d   = '0;
            op_w_d   = 1'b0;
            starve_d = 4'd0;
          end
          r_en_d = ~op_w_d;
          w_en_d = op_w_d;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (!ctrl_freeze) begin
          state_d = StIdle;
          r_en_d  = 1'b0;
          w_en_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        r_en_d  = 1'b0;
        w_en_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      op_w_q   <= 1'b0;
      starve_q <= 4'd0;
      addr_q   <= '0;
      data_q   <= '0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      op_w_q   <= op_w_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      r_en_q   <= r_en_d;
      w_en_q   <= w_en_d;
    end
  end

  assign done = (state_q == StWait) && !ctrl_freeze;

  assign if_freeze  = if_R_en & ~(done & ~grant_q);
  assign mem_freeze = mem_req & ~(done & grant_q);

  // Data goes only to a requester still asking for it; writes return nothing.
  assign if_data_out  = (done && !grant_q && if_R_en) ? ctrl_data_out : '0;
  assign mem_data_out = (done && grant_q && !op_w_q && mem_req) ? ctrl_data_out : '0;

  assign ctrl_addr    = addr_q;
  assign ctrl_data_in = data_q;
  assign ctrl_R_en    = r_en_q;
  assign ctrl_W_en    = w_en_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] if_addr;
  logic          if_R_en;
  logic [DW-1:0] if_data_out;
  logic          if_freeze;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_R_en;
  logic          mem_W_en;
  logic [DW-1:0] mem_data_out;
  logic          mem_freeze;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_data_in;
  logic          ctrl_R_en;
  logic          ctrl_W_en;
  logic [DW-1:0] ctrl_data_out;
  logic          ctrl_freeze;
  logic          mreq;

  assign mreq = mem_R_en | mem_W_en;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_addr      (if_addr),
    .if_R_en      (if_R_en),
    .if_data_out  (if_data_out),
    .if_freeze    (if_freeze),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_R_en     (mem_R_en),
    .mem_W_en     (mem_W_en),
    .mem_data_out (mem_data_out),
    .mem_freeze   (mem_freeze),
    .ctrl_addr    (ctrl_addr),
    .ctrl_data_in (ctrl_data_in),
    .ctrl_R_en    (ctrl_R_en),
    .ctrl_W_en    (ctrl_W_en),
    .ctrl_data_out(ctrl_data_out),
    .ctrl_freeze  (ctrl_freeze)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one in-flight transaction record plus a starvation tally.
  bit            m_busy, m_waiting, m_who, m_write;  // m_who: 0=IF, 1=MEM
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_starve;
  int            glog[$];
  bit            c_if, c_mem;  // completion seen this cycle, per requester

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waiting = 0; m_who = 0; m_write = 0;
    m_addr = '0; m_data = '0; m_starve = 0;
  endtask

  task automatic model_step();
    bit who;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (if_R_en || mreq) begin
        if (mreq && m_starve < SMAX) who = 1;
        else if (if_R_en) who = 0;
        else who = 1;
        glog.push_back(int'(who));
        m_busy = 1; m_waiting = 0; m_who = who;
        if (who) begin
          m_addr = mem_addr; m_data = mem_data_in;
          m_write = mem_W_en && !mem_R_en;
          m_starve = if_R_en ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
        end else begin
          m_addr = if_addr; m_write = 0; m_starve = 0;
        end
      end else begin
        m_starve = 0;
      end
    end else begin
      if (!if_R_en) m_starve = 0;
      if (!m_waiting) m_waiting = 1;
      else if (!ctrl_freeze) m_busy = 0;
    end
  endtask

  task automatic compare();
    bit comp;
    logic [DW-1:0] e_if, e_mem;
    comp  = m_busy && m_waiting && !ctrl_freeze;
    c_if  = comp && !m_who;
    c_mem = comp && m_who;
    e_if  = (c_if && if_R_en) ? ctrl_data_out : '0;
    e_mem = (c_mem && !m_write && mreq) ? ctrl_data_out : '0;
    chk("if_freeze", {63'b0, if_freeze}, {63'b0, if_R_en && !c_if});
    chk("mem_freeze", {63'b0, mem_freeze}, {63'b0, mreq && !c_mem});
    chk("if_data_out", {32'b0, if_data_out}, {32'b0, e_if});
    chk("mem_data_out", {32'b0, mem_data_out}, {32'b0, e_mem});
    chk("ctrl_R_en", {63'b0, ctrl_R_en}, {63'b0, m_busy && !m_write});
    chk("ctrl_W_en", {63'b0, ctrl_W_en}, {63'b0, m_busy && m_write});
    chk("ctrl_addr", {46'b0, ctrl_addr}, {46'b0, m_addr});
    if (m_busy && m_write) chk("ctrl_data_in", {32'b0, ctrl_data_in}, {32'b0, m_data});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Well-behaved requesters: hold a request until its completion, then maybe issue another.
  task automatic drive_rand(input int p_start, input int p_frz);
    int r;
    if (if_R_en ? c_if : 1'b1) begin
      if (!if_R_en || c_if) begin
        if_R_en = ($urandom_range(99) < p_start);
        if_addr = AW'($urandom);
      end
    end
    if (!mreq || c_mem) begin
      mem_R_en = 0; mem_W_en = 0;
      if ($urandom_range(99) < p_start) begin
        r = $urandom_range(9);
        mem_R_en = (r < 4) || (r == 9);
        mem_W_en = (r >= 4);
        mem_addr = AW'($urandom);
        mem_data_in = $urandom;
      end
    end
    ctrl_freeze   = ($urandom_range(99) < p_frz);
    ctrl_data_out = $urandom;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!m_busy && !if_R_en && !mreq) begin
        ok = 1;
        break;
      end
      cycle();
      drive_rand(0, 20);
    end
    chk("drain_timeout", {63'b0, ok}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int frz_cnt;
    int exp_g[6];
    exp_g = '{1, 1, 1, 1, 0, 1};
    rst = 0; if_addr = '0; if_R_en = 1; mem_addr = '0; mem_data_in = '0;
    mem_R_en = 0; mem_W_en = 0; ctrl_data_out = '0; ctrl_freeze = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ren", {63'b0, ctrl_R_en}, 64'd0);
    chk("rst_wen", {63'b0, ctrl_W_en}, 64'd0);
    chk("rst_addr", {46'b0, ctrl_addr}, 64'd0);
    chk("rst_din", {32'b0, ctrl_data_in}, 64'd0);
    chk("rst_if_do", {32'b0, if_data_out}, 64'd0);
    chk("rst_if_frz", {63'b0, if_freeze}, 64'd1);
    if_R_en = 0;
    rst = 1;

    // Hit read from IF.
    drain();
    if_R_en = 1; if_addr = 18'h00010; ctrl_freeze = 0; ctrl_data_out = 32'hDEADBEEF;
    #1 chk("hit_c0_frz", {63'b0, if_freeze}, 64'd1);
    cycle();
    chk("hit_c1_frz", {63'b0, if_freeze}, 64'd1);
    chk("hit_c1_ren", {63'b0, ctrl_R_en}, 64'd1);
    cycle();
    chk("hit_c2_frz", {63'b0, if_freeze}, 64'd0);
    chk("hit_c2_data", {32'b0, if_data_out}, 64'hDEADBEEF);
    chk("hit_c2_addr", {46'b0, ctrl_addr}, 64'h10);
    chk("hit_c2_ren", {63'b0, ctrl_R_en}, 64'd1);
    if_R_en = 0;
    cycle();
    chk("hit_c3_ren", {63'b0, ctrl_R_en}, 64'd0);

    // Miss read from MEM: six WAIT cycles with freeze high.
    drain();
    mem_R_en = 1; mem_addr = 18'h2A5A5; ctrl_freeze = 1;
    #1 frz_cnt = int'(mem_freeze);
    repeat (7) begin
      cycle();
      frz_cnt += int'(mem_freeze);
      chk("miss_addr", {46'b0, ctrl_addr}, 64'h2A5A5);
    end
    ctrl_freeze = 0; ctrl_data_out = 32'hCAFEF00D;
    #1 chk("miss_frz_low", {63'b0, mem_freeze}, 64'd0);
    chk("miss_data", {32'b0, mem_data_out}, 64'hCAFEF00D);
    chk("miss_frz_cnt", 64'(frz_cnt), 64'd8);
    mem_R_en = 0;
    cycle();

    // Simultaneous MEM write and IF read.
    drain();
    mem_W_en = 1; mem_addr = 18'h00020; mem_data_in = 32'h12345678;
    if_R_en = 1; if_addr = 18'h00155; ctrl_freeze = 0;
    cycle();
    chk("sim_wen", {63'b0, ctrl_W_en}, 64'd1);
    chk("sim_ren", {63'b0, ctrl_R_en}, 64'd0);
    chk("sim_din", {32'b0, ctrl_data_in}, 64'h12345678);
    chk("sim_addr", {46'b0, ctrl_addr}, 64'h20);
    cycle();
    chk("sim_mem_done", {63'b0, mem_freeze}, 64'd0);
    chk("sim_if_held", {63'b0, if_freeze}, 64'd1);
    mem_W_en = 0;
    cycle();
    chk("sim_idle_wen", {63'b0, ctrl_W_en}, 64'd0);
    chk("sim_idle_iffrz", {63'b0, if_freeze}, 64'd1);
    cycle();
    chk("sim_if_ren", {63'b0, ctrl_R_en}, 64'd1);
    chk("sim_if_addr", {46'b0, ctrl_addr}, 64'h155);
    ctrl_data_out = 32'h0BADF00D;
    cycle();
    chk("sim_if_done", {63'b0, if_freeze}, 64'd0);
    chk("sim_if_data", {32'b0, if_data_out}, 64'h0BADF00D);
    if_R_en = 0;
    cycle();

    // Starvation: MEM requests continuously while IF waits.
    drain();
    glog.delete();
    mem_R_en = 1; mem_addr = 18'h03000; if_R_en = 1; if_addr = 18'h00111; ctrl_freeze = 0;
    repeat (20) begin
      cycle();
      if (c_if) if_R_en = 0;
    end
    chk("starve_len", {63'b0, glog.size() >= 6}, 64'd1);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("starve_grant", 64'(glog[i]), 64'(exp_g[i]));
    mem_R_en = 0;
    drain();

    // MEM read and write together: only the read goes out.
    mem_R_en = 1; mem_W_en = 1; mem_addr = 18'h00040; mem_data_in = 32'h55AA55AA;
    ctrl_data_out = 32'h13572468;
    cycle();
    chk("rw_ren", {63'b0, ctrl_R_en}, 64'd1);
    chk("rw_wen", {63'b0, ctrl_W_en}, 64'd0);
    cycle();
    chk("rw_data", {32'b0, mem_data_out}, 64'h13572468);
    mem_R_en = 0; mem_W_en = 0;
    cycle();

    // Reset during WAIT of a miss, then reissue.
    drain();
    mem_R_en = 1; mem_addr = 18'h00077; ctrl_freeze = 1;
    repeat (3) cycle();
    #2 rst = 0;
    model_reset();
    #1 chk("arst_ren", {63'b0, ctrl_R_en}, 64'd0);
    chk("arst_addr", {46'b0, ctrl_addr}, 64'd0);
    chk("arst_frz", {63'b0, mem_freeze}, 64'd1);
    cycle();
    rst = 1; ctrl_freeze = 0;
    cycle();
    chk("arst_reissue", {63'b0, ctrl_R_en}, 64'd1);
    chk("arst_addr2", {46'b0, ctrl_addr}, 64'h77);
    cycle();
    chk("arst_done", {63'b0, mem_freeze}, 64'd0);
    mem_R_en = 0;
    cycle();

    // Randomized traffic.
    drain();
    repeat (3000) begin
      cycle();
      drive_rand(60, 40);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
